hidden_unit_reader: RTL and testbench

- Read-side sequencer for the hidden-unit RAM (32 x 8, synchronous write, registered read address, read data valid one cycle after the address is presented).
- On a start pulse it sweeps RAM addresses 0..NUM_UNITS-1. It absorbs the RAM's one-cycle read latency in a 2-entry prefetch buffer.
- It streams each hidden-unit value, with its index, to the output-layer datapath over a valid/ready handshake.
- Owns the RAM address while busy. Never writes the RAM.

---
 rtl/hidden_unit_reader_if.sv | 25 ++
 rtl/hidden_unit_reader.sv | 114 +++++++++++
 tb/tb_hidden_unit_reader.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/hidden_unit_reader_if.sv
// Bundle between the hidden-unit reader, the hidden-unit RAM read port and
// the output-layer stream consumer.
interface hidden_unit_reader_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_q;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_idx;
  logic                  out_last;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output ram_addr, ram_we, out_data, out_idx, out_last, out_valid,
    input  ram_q, out_ready
  );

  modport slave (
    input  ram_addr, ram_we, out_data, out_idx, out_last, out_valid,
    output ram_q, out_ready
  );
endinterface

// File: rtl/hidden_unit_reader.sv
// Sweeps the hidden-unit RAM from address 0 to NUM_UNITS-1 and streams each value
// with its index, hiding the RAM's one-cycle read latency behind a 2-entry buffer.
module hidden_unit_reader #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_UNITS  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  hidden_unit_reader_if.master bus,
  output logic                 busy,
  output logic                 done
);

  localparam logic [ADDR_WIDTH:0]   LAST_CNT = (ADDR_WIDTH+1)'(NUM_UNITS - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_UNITS - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH:0]   issue_cnt;
  logic [ADDR_WIDTH-1:0] addr_hold;
  logic [ADDR_WIDTH-1:0] tag;
  logic                  inflight;
  logic                  issue;
  logic                  pop;
  logic                  valid;
  logic [DATA_WIDTH-1:0] buf_data [2];
  logic [ADDR_WIDTH-1:0] buf_idx  [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;
  logic [2:0]            occupancy;

  assign valid = (count != 2'd0);
  assign pop   = valid && bus.out_ready;

  // A beat leaving this cycle frees its slot, which keeps the stream at one beat per cycle.
  assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:  if (start) state_next = READ;
      READ: begin
        if (occupancy < 3'd2) begin
          issue = 1'b1;
          if (issue_cnt == LAST_CNT) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight && !valid) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt  <= '0;
      addr_hold  <= '0;
      tag        <= '0;
      inflight   <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_idx[0]  <= '0;
      buf_idx[1]  <= '0;
    end else begin
      if (state == IDLE && start) begin
        issue_cnt <= '0;
      end else if (issue) begin
        issue_cnt <= issue_cnt + 1'b1;
        addr_hold <= issue_cnt[ADDR_WIDTH-1:0];
        tag       <= issue_cnt[ADDR_WIDTH-1:0];
      end
      inflight <= issue;
      if (inflight) begin
        buf_data[wr_ptr] <= bus.ram_q;
        buf_idx[wr_ptr]  <= tag;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({inflight, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign bus.ram_addr  = issue ? issue_cnt[ADDR_WIDTH-1:0] : addr_hold;
  assign bus.ram_we    = 1'b0;
  assign bus.out_valid = valid;
  assign bus.out_data  = buf_data[rd_ptr];
  assign bus.out_idx   = buf_idx[rd_ptr];
  assign bus.out_last  = valid && (buf_idx[rd_ptr] == LAST_IDX);
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_hidden_unit_reader.sv
// Directed bench for hidden_unit_reader: full sweeps under several ready patterns,
// restart while busy, async reset mid-sweep, and a single-unit instance.
module tb_hidden_unit_reader;

  localparam int N = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic ready = 1'b0;
  logic busy, done;
  logic start1 = 1'b0;
  logic busy1, done1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  hidden_unit_reader_if #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) bus ();
  hidden_unit_reader_if #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) bus1 ();

  hidden_unit_reader #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .NUM_UNITS(N)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus.master), .busy(busy), .done(done)
  );

  hidden_unit_reader #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .NUM_UNITS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .bus(bus1.master), .busy(busy1), .done(done1)
  );

  // Behavioural RAMs: registered address, data visible the cycle after.
  logic [7:0] mem  [N];
  logic [7:0] mem1 [N];
  logic [4:0] ram_areg = '0;
  logic [4:0] ram1_areg = '0;

  always @(posedge clk) begin
    ram_areg  <= bus.ram_addr;
    ram1_areg <= bus1.ram_addr;
  end

  assign bus.ram_q      = mem[ram_areg];
  assign bus.out_ready  = ready;
  assign bus1.ram_q     = mem1[ram1_areg];
  assign bus1.out_ready = 1'b1;

  task automatic checkOutput(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // mode 0: ready always high, 1: stall 10 cycles after first valid, 2: random ready.
  task automatic applyStimulus(input int mode, input int restart_at);
    int  exp_idx, done_cnt, first_valid, first_beat, last_beat;
    bit  finished, restarted, we_seen, ovf, extra;
    exp_idx = 0; done_cnt = 0; first_valid = -1; first_beat = -1; last_beat = -1;
    finished = 0; restarted = 0; we_seen = 0; ovf = 0; extra = 0;
    @(negedge clk);
    start = 1'b1;
    ready = (mode == 0);
    for (int cyc = 1; cyc <= 400 && !finished; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (restart_at >= 0 && !restarted && exp_idx == restart_at) begin
        start = 1'b1;
        restarted = 1;
      end
      if (bus.out_valid && first_valid < 0) first_valid = cyc;
      case (mode)
        0:       ready = 1'b1;
        1:       ready = (first_valid >= 0) && (cyc >= first_valid + 10);
        default: ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      we_seen |= bus.ram_we;
      ovf |= dut.inflight && (dut.count == 2'd2) && !(bus.out_valid && ready);
      if (cyc == 1) checkOutput("busy_rise", busy, 1);
      if (mode == 1 && first_valid >= 0 && !ready) begin
        checkOutput("stall_data", bus.out_data, 8'hA0);
        checkOutput("stall_idx", bus.out_idx, 0);
        checkOutput("stall_addr", bus.ram_addr, 1);
      end
      if (bus.out_valid && ready) begin
        checkOutput("beat_idx", bus.out_idx, exp_idx);
        checkOutput("beat_data", bus.out_data, (8'hA0 + exp_idx) & 8'hFF);
        checkOutput("beat_last", bus.out_last, (exp_idx == N-1) ? 1 : 0);
        if (first_beat < 0) first_beat = cyc;
        last_beat = cyc;
        exp_idx++;
      end
      if (done) begin
        done_cnt++;
        checkOutput("done_after_last", cyc - last_beat, 1);
        finished = 1;
      end
    end
    start = 1'b0;
    checkOutput("beats", exp_idx, N);
    checkOutput("done_cnt", done_cnt, 1);
    checkOutput("ram_we", we_seen, 0);
    checkOutput("no_overflow", ovf, 0);
    if (mode == 0) begin
      checkOutput("first_valid", first_valid, 3);
      checkOutput("contiguous", last_beat - first_beat, N-1);
    end
    @(negedge clk);
    checkOutput("busy_idle", busy, 0);
    repeat (5) begin
      @(negedge clk);
      extra |= bus.out_valid | busy | done;
    end
    checkOutput("no_second_sweep", extra, 0);
  endtask

  initial begin
    int beats, beats1, done1_cnt;
    bit addr1_moved;
    for (int i = 0; i < N; i++) begin
      mem[i]  = 8'(8'hA0 + i);
      mem1[i] = 8'hEE;
    end
    mem1[0] = 8'h5C;

    repeat (2) @(negedge clk);
    checkOutput("rst_valid", bus.out_valid, 0);
    checkOutput("rst_data", bus.out_data, 0);
    checkOutput("rst_idx", bus.out_idx, 0);
    checkOutput("rst_last", bus.out_last, 0);
    checkOutput("rst_addr", bus.ram_addr, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] full sweep, ready high");
    applyStimulus(0, -1);
    $display("[TB] stall after first valid");
    applyStimulus(1, -1);
    $display("[TB] random ready, three sweeps");
    repeat (3) applyStimulus(2, -1);
    $display("[TB] start re-pulsed while busy");
    applyStimulus(0, 5);

    $display("[TB] async reset at beat 12");
    beats = 0;
    @(negedge clk);
    start = 1'b1;
    ready = 1'b1;
    for (int cyc = 0; cyc < 100 && beats < 12; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (bus.out_valid && ready) beats++;
    end
    checkOutput("pre_reset_beats", beats, 12);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("arst_valid", bus.out_valid, 0);
    checkOutput("arst_data", bus.out_data, 0);
    checkOutput("arst_idx", bus.out_idx, 0);
    checkOutput("arst_last", bus.out_last, 0);
    checkOutput("arst_addr", bus.ram_addr, 0);
    checkOutput("arst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(0, -1);

    $display("[TB] single-unit instance");
    beats1 = 0; done1_cnt = 0; addr1_moved = 0;
    @(negedge clk);
    start1 = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      start1 = 1'b0;
      #1;
      addr1_moved |= (bus1.ram_addr != 5'd0);
      if (bus1.out_valid) begin
        beats1++;
        checkOutput("one_data", bus1.out_data, 8'h5C);
        checkOutput("one_idx", bus1.out_idx, 0);
        checkOutput("one_last", bus1.out_last, 1);
      end
      if (done1) begin
        done1_cnt++;
        checkOutput("one_done_cyc", cyc, 4);
      end
    end
    checkOutput("one_beats", beats1, 1);
    checkOutput("one_done_cnt", done1_cnt, 1);
    checkOutput("one_no_reads", addr1_moved, 0);
    checkOutput("one_busy_idle", busy1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
